// File: rtl/toggle_req_responder.sv
// Responder side of a two-phase toggle req/ack link.
// Synchronizes req_tog, presents each event on valid/ready, acks on completion.
module toggle_req_responder #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_tog,
  input  logic [DATA_W-1:0] req_data,
  output logic              evt_valid,
  output logic [DATA_W-1:0] evt_data,
  input  logic              evt_ready,
  output logic              ack_tog,
  output logic [CNT_W-1:0]  evt_count,
  output logic              proto_err,
  input  logic              err_clr
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_seen_q, req_seen_d;
  logic                   evt_valid_q, evt_valid_d;
  logic [DATA_W-1:0]      evt_data_q, evt_data_d;
  logic                   ack_tog_q, ack_tog_d;
  logic [CNT_W-1:0]       evt_count_q, evt_count_d;
  logic                   proto_err_q, proto_err_d;

  logic req_sync;
  logic toggle_det;
  logic viol;

  assign req_sync   = sync_q[SYNC_STAGES-1];
  assign toggle_det = req_sync ^ req_seen_q;

  always_comb begin
    sync_d[0] = req_tog;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    req_seen_d  = req_seen_q;
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    ack_tog_d   = ack_tog_q;
    evt_count_d = evt_count_q;
    viol        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (toggle_det) begin
          evt_data_d  = req_data;
          req_seen_d  = req_sync;
          evt_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (evt_valid_q && evt_ready) begin
          evt_valid_d = 1'b0;
          ack_tog_d   = ~ack_tog_q;
          if (evt_count_q != CNT_MAX) begin
            evt_count_d = evt_count_q + 1'b1;
          end
          state_d = IDLE;
        end
        // a second toggle while pending is dropped, only flagged
        if (toggle_det) begin
          viol       = 1'b1;
          req_seen_d = req_sync;
        end
      end
      default: state_d = IDLE;
    endcase
    proto_err_d = (proto_err_q & ~err_clr) | viol;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      req_seen_q  <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      ack_tog_q   <= 1'b0;
      evt_count_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      req_seen_q  <= req_seen_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      ack_tog_q   <= ack_tog_d;
      evt_count_q <= evt_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_data  = evt_data_q;
  assign ack_tog   = ack_tog_q;
  assign evt_count = evt_count_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_toggle_req_responder.sv
// Bench for toggle_req_responder: directed vector table, CNT_W=2 instance
// sequences, and randomized run against an event-level reference model.
module tb_toggle_req_responder;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_tog;
  logic [7:0] req_data;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_ready;
  logic       ack_tog;
  logic [7:0] evt_count;
  logic       proto_err;
  logic       err_clr;

  logic       r2_reset;
  logic       r2_tog;
  logic [7:0] r2_data;
  logic       r2_valid;
  logic [7:0] r2_edata;
  logic       r2_ready;
  logic       r2_ack;
  logic [1:0] r2_count;
  logic       r2_perr;
  logic       r2_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  toggle_req_responder #(.DATA_W(8), .SYNC_STAGES(S), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_tog(req_tog), .req_data(req_data),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .ack_tog(ack_tog), .evt_count(evt_count), .proto_err(proto_err),
    .err_clr(err_clr)
  );

  toggle_req_responder #(.DATA_W(8), .SYNC_STAGES(S), .CNT_W(2)) dut2 (
    .clk(clk), .reset(r2_reset), .req_tog(r2_tog), .req_data(r2_data),
    .evt_valid(r2_valid), .evt_data(r2_edata), .evt_ready(r2_ready),
    .ack_tog(r2_ack), .evt_count(r2_count), .proto_err(r2_perr),
    .err_clr(r2_clr)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       tog;
    logic [7:0] data;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [7:0] d;
    logic       a;
    logic [7:0] c;
    logic       e;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic tog, input logic [7:0] data,
                              input logic rdy, input logic clr,
                              input logic v, input logic [7:0] d,
                              input logic a, input logic [7:0] c,
                              input logic e);
    vec_t r;
    r.tog = tog; r.data = data; r.rdy = rdy; r.clr = clr;
    r.v = v; r.d = d; r.a = a; r.c = c; r.e = e;
    vecs.push_back(r);
  endfunction

  // reference model: event-level view of the link
  bit         m_hist[$];
  bit         m_seen, m_pend, m_ack, m_perr;
  logic [7:0] m_data;
  int         m_cnt;

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < S; i++) m_hist.push_back(1'b0);
    m_seen = 0; m_pend = 0; m_ack = 0; m_perr = 0;
    m_data = 8'h00; m_cnt = 0;
  endfunction

  function automatic void model_step();
    bit sync;
    bit det;
    bit viol;
    if (reset) begin
      model_reset();
      return;
    end
    sync = m_hist[S-1];
    m_hist.push_front(req_tog);
    void'(m_hist.pop_back());
    det  = (sync != m_seen);
    viol = 0;
    if (!m_pend) begin
      if (det) begin
        m_pend = 1; m_data = req_data; m_seen = sync;
      end
    end else begin
      if (evt_ready) begin
        m_pend = 0;
        m_ack  = !m_ack;
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      if (det) begin
        viol = 1; m_seen = sync;
      end
    end
    if (err_clr) m_perr = 0;
    if (viol) m_perr = 1;
  endfunction

  initial begin
    logic [7:0] dprev;
    logic       tg;
    logic       ab;
    int         n;

    reset = 1; req_tog = 0; req_data = 0; evt_ready = 0; err_clr = 0;
    r2_reset = 1; r2_tog = 0; r2_data = 0; r2_ready = 0; r2_clr = 0;

    // directed vectors: inputs before an edge, outputs after it
    add(1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 1, 8'hA5, 0, 0, 0);
    add(1, 8'hA5, 0, 0, 1, 8'hA5, 0, 0, 0);
    add(1, 8'hA5, 1, 0, 0, 8'hA5, 1, 1, 0);
    add(1, 8'hA5, 1, 0, 0, 8'hA5, 1, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      tg    = (k % 2 == 0);
      ab    = (k % 2 == 1);
      dprev = (k == 1) ? 8'hA5 : 8'(k - 1);
      add(tg, 8'(k), 1, 0, 0, dprev, ab, 8'(k), 0);
      add(tg, 8'(k), 1, 0, 0, dprev, ab, 8'(k), 0);
      add(tg, 8'(k), 1, 0, 1, 8'(k), ab, 8'(k), 0);
      add(tg, 8'(k), 1, 0, 0, 8'(k), ~ab, 8'(k + 1), 0);
    end
    add(0, 8'h11, 0, 0, 0, 8'h04, 1, 5, 0);
    add(0, 8'h11, 0, 0, 0, 8'h04, 1, 5, 0);
    add(0, 8'h11, 0, 0, 1, 8'h11, 1, 5, 0);
    add(1, 8'h22, 0, 0, 1, 8'h11, 1, 5, 0);
    add(1, 8'h22, 0, 0, 1, 8'h11, 1, 5, 0);
    add(1, 8'h22, 0, 0, 1, 8'h11, 1, 5, 1);
    add(1, 8'h22, 1, 0, 0, 8'h11, 0, 6, 1);
    add(1, 8'h22, 0, 0, 0, 8'h11, 0, 6, 1);
    add(1, 8'h22, 0, 0, 0, 8'h11, 0, 6, 1);
    add(1, 8'h22, 0, 1, 0, 8'h11, 0, 6, 0);
    add(1, 8'h22, 0, 0, 0, 8'h11, 0, 6, 0);
    add(0, 8'h33, 0, 0, 0, 8'h11, 0, 6, 0);
    add(0, 8'h33, 0, 0, 0, 8'h11, 0, 6, 0);
    add(0, 8'h33, 0, 0, 1, 8'h33, 0, 6, 0);
    add(1, 8'h44, 0, 0, 1, 8'h33, 0, 6, 0);
    add(1, 8'h44, 0, 0, 1, 8'h33, 0, 6, 0);
    add(1, 8'h44, 1, 1, 0, 8'h33, 1, 7, 1);
    add(1, 8'h44, 0, 0, 0, 8'h33, 1, 7, 1);
    add(1, 8'h44, 0, 0, 0, 8'h33, 1, 7, 1);

    @(negedge clk);
    @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_data", evt_data, 0);
    check("rst_ack", ack_tog, 0);
    check("rst_count", evt_count, 0);
    check("rst_perr", proto_err, 0);
    reset = 0;
    r2_reset = 0;

    foreach (vecs[i]) begin
      req_tog = vecs[i].tog; req_data = vecs[i].data;
      evt_ready = vecs[i].rdy; err_clr = vecs[i].clr;
      @(negedge clk);
      check($sformatf("v%0d_valid", i), evt_valid, vecs[i].v);
      check($sformatf("v%0d_data", i), evt_data, vecs[i].d);
      check($sformatf("v%0d_ack", i), ack_tog, vecs[i].a);
      check($sformatf("v%0d_count", i), evt_count, vecs[i].c);
      check($sformatf("v%0d_perr", i), proto_err, vecs[i].e);
    end

    // CNT_W=2 instance: saturation then reset while holding
    r2_ready = 1;
    for (int k = 1; k <= 5; k++) begin
      r2_tog  = ~r2_tog;
      r2_data = 8'(8'h50 + k);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!r2_valid && n < 10);
      check($sformatf("sat%0d_valid", k), r2_valid, 1);
      check($sformatf("sat%0d_data", k), r2_edata, 8'h50 + k);
      @(negedge clk);
      check($sformatf("sat%0d_done", k), r2_valid, 0);
      check($sformatf("sat%0d_count", k), r2_count, (k < 3) ? k : 3);
      check($sformatf("sat%0d_ack", k), r2_ack, k % 2);
    end
    r2_ready = 0;
    r2_tog   = ~r2_tog;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!r2_valid && n < 10);
    check("hold_valid", r2_valid, 1);
    r2_reset = 1;
    @(negedge clk);
    check("hrst_valid", r2_valid, 0);
    check("hrst_ack", r2_ack, 0);
    check("hrst_count", r2_count, 0);
    r2_reset = 0;

    // randomized run against the model
    reset = 1;
    evt_ready = 0; err_clr = 0;
    @(posedge clk);
    model_step();
    @(negedge clk);
    reset = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 5) == 0) req_tog = ~req_tog;
      req_data  = 8'($urandom);
      evt_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("rnd_valid", evt_valid, m_pend);
      check("rnd_data", evt_data, m_data);
      check("rnd_ack", ack_tog, m_ack);
      check("rnd_count", evt_count, m_cnt);
      check("rnd_perr", proto_err, m_perr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
